// File: rtl/graphics_rect_fill.sv
`timescale 1ns/1ps
// graphics_rect_fill
// Rasterises a solid, axis-aligned rectangle into a stream of pixel beats.
// Software writes two corner points and a color over an Avalon-MM CSR slave.
// Writing the color starts the fill. Pixels leave on an Avalon-ST source in
// row-major order: y is the outer loop and x is the inner loop, both ascending.
//
// Ports:
//   clk, reset_n          : system clock; asynchronous active-low reset
//   csr_address/write/... : CSR slave. Address 0 is POINT1, 1 is POINT2 and
//                           2 is COLOR. Reads return {31'b0, busy}.
//   csr_waitrequest       : holds a write off while a fill is in progress
//   st_data               : {zero padding, x, y, color}
//   st_valid/st_ready     : stream handshake
//   st_startofpacket      : first pixel of a rectangle
//   st_endofpacket        : last pixel of a rectangle
module graphics_rect_fill #(
  parameter int COORD_DATA_WIDTH  = 10,
  parameter int COLOR_DATA_WIDTH  = 12,
  parameter int MM_CSR_ADDR_WIDTH = 4,
  parameter int ST_DATA_WIDTH     = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [MM_CSR_ADDR_WIDTH-1:0] csr_address,
  input  logic                         csr_write,
  input  logic [31:0]                  csr_writedata,
  input  logic                         csr_read,
  output logic [31:0]                  csr_readdata,
  output logic                         csr_waitrequest,
  output logic [ST_DATA_WIDTH-1:0]     st_data,
  output logic                         st_valid,
  input  logic                         st_ready,
  output logic                         st_startofpacket,
  output logic                         st_endofpacket
);

  localparam int CW = COORD_DATA_WIDTH;
  localparam int KW = COLOR_DATA_WIDTH;

  localparam logic [MM_CSR_ADDR_WIDTH-1:0] ADDR_POINT1 = MM_CSR_ADDR_WIDTH'(0);
  localparam logic [MM_CSR_ADDR_WIDTH-1:0] ADDR_POINT2 = MM_CSR_ADDR_WIDTH'(1);
  localparam logic [MM_CSR_ADDR_WIDTH-1:0] ADDR_COLOR  = MM_CSR_ADDR_WIDTH'(2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_EMIT  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [2*CW-1:0] p1_q, p1_d, p2_q, p2_d;
  logic [KW-1:0]   color_q, color_d, fill_color_q, fill_color_d;
  logic [CW-1:0]   xmin_q, xmin_d, xmax_q, xmax_d;
  logic [CW-1:0]   ymin_q, ymin_d, ymax_q, ymax_d;
  logic [CW-1:0]   cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic            st_valid_q, st_valid_d;
  logic            sop_q, sop_d, eop_q, eop_d;

  logic          busy, wr_accept;
  logic [CW-1:0] p1_x, p1_y, p2_x, p2_y;
  logic [CW-1:0] lo_x, hi_x, lo_y, hi_y;
  logic [CW-1:0] nx, ny;
  logic          unused_bits;

  // The read strobe is not needed: status is presented for any read cycle.
  assign unused_bits = ^{csr_read, csr_writedata};

  assign busy            = (state_q != S_IDLE);
  assign wr_accept       = csr_write && !busy;
  assign csr_waitrequest = csr_write && busy;
  assign csr_readdata    = {31'b0, busy};

  assign st_valid         = st_valid_q;
  assign st_startofpacket = sop_q;
  assign st_endofpacket   = eop_q;
  assign st_data          = ST_DATA_WIDTH'({cur_x_q, cur_y_q, fill_color_q});

  always_comb begin
    p1_x = p1_q[2*CW-1:CW];
    p1_y = p1_q[CW-1:0];
    p2_x = p2_q[2*CW-1:CW];
    p2_y = p2_q[CW-1:0];
    lo_x = (p1_x < p2_x) ? p1_x : p2_x;
    hi_x = (p1_x < p2_x) ? p2_x : p1_x;
    lo_y = (p1_y < p2_y) ? p1_y : p2_y;
    hi_y = (p1_y < p2_y) ? p2_y : p1_y;
  end

  always_comb begin
    state_d      = state_q;
    p1_d         = p1_q;
    p2_d         = p2_q;
    color_d      = color_q;
    fill_color_d = fill_color_q;
    xmin_d       = xmin_q;
    xmax_d       = xmax_q;
    ymin_d       = ymin_q;
    ymax_d       = ymax_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    st_valid_d   = st_valid_q;
    sop_d        = sop_q;
    eop_d        = eop_q;
    nx           = cur_x_q;
    ny           = cur_y_q;

    // Writes can only be accepted in IDLE, so the register file never
    // changes underneath a fill in progress.
    if (wr_accept) begin
      case (csr_address)
        ADDR_POINT1: p1_d = csr_writedata[2*CW-1:0];
        ADDR_POINT2: p2_d = csr_writedata[2*CW-1:0];
        ADDR_COLOR: begin
          color_d = csr_writedata[KW-1:0];
          state_d = S_SETUP;
        end
        default: ;
      endcase
    end

    case (state_q)
      S_SETUP: begin
        xmin_d       = lo_x;
        xmax_d       = hi_x;
        ymin_d       = lo_y;
        ymax_d       = hi_y;
        cur_x_d      = lo_x;
        cur_y_d      = lo_y;
        fill_color_d = color_q;
        // The first beat is registered here so it is valid as EMIT begins.
        st_valid_d   = 1'b1;
        sop_d        = 1'b1;
        eop_d        = (lo_x == hi_x) && (lo_y == hi_y);
        state_d      = S_EMIT;
      end
      S_EMIT: begin
        if (st_ready) begin
          if (eop_q) begin
            st_valid_d = 1'b0;
            sop_d      = 1'b0;
            eop_d      = 1'b0;
            state_d    = S_IDLE;
          end else begin
            // Equality tests only, so an all-ones xmax/ymax never wraps.
            if (cur_x_q == xmax_q) begin
              nx = xmin_q;
              ny = cur_y_q + 1'b1;
            end else begin
              nx = cur_x_q + 1'b1;
              ny = cur_y_q;
            end
            cur_x_d = nx;
            cur_y_d = ny;
            sop_d   = 1'b0;
            eop_d   = (nx == xmax_q) && (ny == ymax_q);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      p1_q         <= '0;
      p2_q         <= '0;
      color_q      <= '0;
      fill_color_q <= '0;
      xmin_q       <= '0;
      xmax_q       <= '0;
      ymin_q       <= '0;
      ymax_q       <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      st_valid_q   <= 1'b0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      p1_q         <= p1_d;
      p2_q         <= p2_d;
      color_q      <= color_d;
      fill_color_q <= fill_color_d;
      xmin_q       <= xmin_d;
      xmax_q       <= xmax_d;
      ymin_q       <= ymin_d;
      ymax_q       <= ymax_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      st_valid_q   <= st_valid_d;
      sop_q        <= sop_d;
      eop_q        <= eop_d;
    end
  end

endmodule

// File: tb/tb_graphics_rect_fill.sv
`timescale 1ns/1ps
// Bench for graphics_rect_fill: table of rectangles with expected beat count
// and first/last pixel, random rectangles, and hand sequences for the
// busy-write hold-off and the mid-fill reset.
module tb_graphics_rect_fill;

  localparam int CW  = 10;
  localparam int KW  = 12;
  localparam int AW  = 4;
  localparam int DW  = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] csr_address;
  logic          csr_write;
  logic [31:0]   csr_writedata;
  logic          csr_read;
  logic [31:0]   csr_readdata;
  logic          csr_waitrequest;
  logic [DW-1:0] st_data;
  logic          st_valid;
  logic          st_ready;
  logic          st_startofpacket;
  logic          st_endofpacket;

  always #5 clk = ~clk;

  graphics_rect_fill #(
    .COORD_DATA_WIDTH (CW),
    .COLOR_DATA_WIDTH (KW),
    .MM_CSR_ADDR_WIDTH(AW),
    .ST_DATA_WIDTH    (DW)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .csr_address     (csr_address),
    .csr_write       (csr_write),
    .csr_writedata   (csr_writedata),
    .csr_read        (csr_read),
    .csr_readdata    (csr_readdata),
    .csr_waitrequest (csr_waitrequest),
    .st_data         (st_data),
    .st_valid        (st_valid),
    .st_ready        (st_ready),
    .st_startofpacket(st_startofpacket),
    .st_endofpacket  (st_endofpacket)
  );

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  typedef struct {
    int x1, y1, x2, y2, color, mode;
    int exp_count, fx, fy, lx, ly;
  } vec_t;

  beat_t       exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          ready_mode = 0;
  int          obs_cnt = 0;
  logic [31:0] obs_first = '0;
  logic [31:0] obs_last = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pix(input int x, input int y, input int c);
    logic [31:0] r;
    r = (32'(x) << 22) | (32'(y) << 12) | (32'(c) & 32'hFFF);
    return r;
  endfunction

  function automatic logic [31:0] pt(input int x, input int y);
    logic [31:0] r;
    r = ($urandom() & 32'hFFF0_0000) | (32'(x) << 10) | 32'(y);
    return r;
  endfunction

  // Reference model: enumerate the rectangle with plain nested loops.
  task automatic model_push(input int x1, input int y1, input int x2, input int y2, input int c);
    int xmin, xmax, ymin, ymax;
    beat_t b;
    xmin = (x1 < x2) ? x1 : x2;
    xmax = (x1 < x2) ? x2 : x1;
    ymin = (y1 < y2) ? y1 : y2;
    ymax = (y1 < y2) ? y2 : y1;
    for (int y = ymin; y <= ymax; y++) begin
      for (int x = xmin; x <= xmax; x++) begin
        b.data = pix(x, y, c);
        b.sop  = (x == xmin) && (y == ymin);
        b.eop  = (x == xmax) && (y == ymax);
        exp_q.push_back(b);
      end
    end
  endtask

  // Stream monitor: every valid beat must match the head of the model queue.
  always @(negedge clk) begin
    if (reset_n && st_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", st_data);
      end else begin
        check("beat_data", st_data, exp_q[0].data);
        check("beat_sop", 32'(st_startofpacket), 32'(exp_q[0].sop));
        check("beat_eop", 32'(st_endofpacket), 32'(exp_q[0].eop));
        if (st_ready) begin
          if (obs_cnt == 0) obs_first = st_data;
          obs_last = st_data;
          obs_cnt++;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Sink ready: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random.
  initial begin
    int rcnt;
    rcnt = 0;
    st_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: st_ready = 1'b1;
        1: st_ready = (rcnt % 3 == 0);
        default: st_ready = 1'($urandom_range(0, 1));
      endcase
      rcnt++;
    end
  end

  // Starts just after a rising edge; returns just after the accepting edge.
  task automatic csr_wr(input int a, input logic [31:0] d, output int waits);
    csr_address   = AW'(a);
    csr_writedata = d;
    csr_write     = 1'b1;
    waits         = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!csr_waitrequest) break;
      waits++;
    end
    if (waits >= 300) begin
      n_cmp++;
      n_err++;
      $display("FAIL write_timeout: waitrequest still 1, expected 0");
    end
    @(posedge clk);
    #1;
    csr_write = 1'b0;
  endtask

  task automatic rd_busy(input string name, input logic [31:0] exp);
    csr_read = 1'b1;
    #1;
    check(name, csr_readdata, exp);
    csr_read = 1'b0;
  endtask

  // Waits (bounded) for the model queue to drain, then checks the block idles.
  task automatic wait_drain(input int budget, output int cyc);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    check("end_valid", 32'(st_valid), 32'd0);
    rd_busy("end_busy", 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_fill(input vec_t v);
    int w, cyc;
    obs_cnt    = 0;
    ready_mode = v.mode;
    csr_wr(0, pt(v.x1, v.y1), w);
    csr_wr(1, pt(v.x2, v.y2), w);
    csr_wr(3, $urandom(), w);
    model_push(v.x1, v.y1, v.x2, v.y2, v.color);
    csr_wr(2, ($urandom() & 32'hFFFF_F000) | 32'(v.color), w);
    check("idle_write_wait", 32'(w), 32'd0);
    @(negedge clk);
    check("setup_valid", 32'(st_valid), 32'd0);
    rd_busy("setup_busy", 32'd1);
    @(negedge clk);
    check("first_valid", 32'(st_valid), 32'd1);
    #1;
    wait_drain(80 * v.exp_count + 80, cyc);
    if (v.mode == 0) check("burst_cycles", 32'(cyc), 32'(v.exp_count - 1));
    check("beat_count", 32'(obs_cnt), 32'(v.exp_count));
    check("first_pixel", obs_first, pix(v.fx, v.fy, v.color));
    check("last_pixel", obs_last, pix(v.lx, v.ly, v.color));
  endtask

  vec_t vecs[$];

  initial begin
    vec_t v;
    int   w, cyc, d;

    //            x1    y1    x2    y2   color  mode cnt  fx    fy    lx    ly
    vecs.push_back('{2,    3,    4,    4,    'h5,   0,   6,   2,    3,    4,    4});
    vecs.push_back('{10,   7,    8,    5,    'hA,   0,   9,   8,    5,    10,   7});
    vecs.push_back('{0,    0,    0,    0,    'h1,   0,   1,   0,    0,    0,    0});
    vecs.push_back('{5,    5,    6,    6,    'h3C,  1,   4,   5,    5,    6,    6});
    vecs.push_back('{7,    9,    1,    9,    'hFFF, 2,   7,   1,    9,    7,    9});
    vecs.push_back('{3,    4,    3,    0,    'h123, 1,   5,   3,    0,    3,    4});
    vecs.push_back('{1023, 1023, 1021, 1022, 'h7E7, 0,   6,   1021, 1022, 1023, 1023});

    reset_n       = 1'b0;
    csr_address   = '0;
    csr_write     = 1'b0;
    csr_writedata = '0;
    csr_read      = 1'b0;
    #12;
    check("rst_valid", 32'(st_valid), 32'd0);
    check("rst_sop", 32'(st_startofpacket), 32'd0);
    check("rst_eop", 32'(st_endofpacket), 32'd0);
    check("rst_data", st_data, 32'd0);
    check("rst_wait", 32'(csr_waitrequest), 32'd0);
    rd_busy("rst_busy", 32'd0);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) run_fill(vecs[i]);

    // Random rectangles, corners in random order, random sink behaviour.
    for (int i = 0; i < 20; i++) begin
      v.x1 = $urandom_range(0, 1023);
      v.y1 = $urandom_range(0, 1023);
      d = $urandom_range(0, 4);
      v.x2 = (v.x1 + d > 1023) ? 1023 : v.x1 + d;
      d = $urandom_range(0, 4);
      v.y2 = (v.y1 + d > 1023) ? 1023 : v.y1 + d;
      if ($urandom_range(0, 1) == 1) begin
        d = v.x1; v.x1 = v.x2; v.x2 = d;
      end
      if ($urandom_range(0, 1) == 1) begin
        d = v.y1; v.y1 = v.y2; v.y2 = d;
      end
      v.color = $urandom_range(0, 4095);
      v.mode  = $urandom_range(0, 2);
      v.fx = (v.x1 < v.x2) ? v.x1 : v.x2;
      v.lx = (v.x1 < v.x2) ? v.x2 : v.x1;
      v.fy = (v.y1 < v.y2) ? v.y1 : v.y2;
      v.ly = (v.y1 < v.y2) ? v.y2 : v.y1;
      v.exp_count = (v.lx - v.fx + 1) * (v.ly - v.fy + 1);
      run_fill(v);
    end

    // COLOR write while busy is held off until the first fill's eop handshake.
    ready_mode = 0;
    obs_cnt    = 0;
    csr_wr(0, pt(0, 0), w);
    csr_wr(1, pt(1, 1), w);
    model_push(0, 0, 1, 1, 'h7);
    csr_wr(2, 32'h7, w);
    model_push(0, 0, 1, 1, 'h9);
    csr_wr(2, 32'h9, w);
    check("busy_wait_cycles", 32'(w), 32'd5);
    wait_drain(100, cyc);
    check("b2b_beat_count", 32'(obs_cnt), 32'd8);
    check("b2b_last_pixel", obs_last, pix(1, 1, 'h9));

    // Reset during the third beat of a 3x3 fill.
    obs_cnt = 0;
    csr_wr(0, pt(4, 4), w);
    csr_wr(1, pt(6, 6), w);
    model_push(4, 4, 6, 6, 'h2A);
    csr_wr(2, 32'h2A, w);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("pre_reset_valid", 32'(st_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_valid", 32'(st_valid), 32'd0);
    check("async_eop", 32'(st_endofpacket), 32'd0);
    check("async_data", st_data, 32'd0);
    exp_q.delete();
    rd_busy("reset_busy", 32'd0);
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    rd_busy("post_reset_busy", 32'd0);
    check("post_reset_beats", 32'(obs_cnt), 32'd2);
    obs_cnt = 0;
    model_push(0, 0, 0, 0, 'h33);
    csr_wr(2, 32'h33, w);
    wait_drain(100, cyc);
    check("post_reset_count", 32'(obs_cnt), 32'd1);
    check("post_reset_pixel", obs_first, pix(0, 0, 'h33));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/graphics_rect_fill.md
Name: graphics_rect_fill

Overview:
- Avalon-MM CSR slave plus Avalon-ST pixel source that rasterises a solid, axis-aligned rectangle into a stream of pixel_t beats (x, y, color).
- Sits directly upstream of the pixel sink/framebuffer writer that consumes pixel_t.
- Software writes two corner points and a color; writing the color starts the fill.
- Uses the RECT_FILL_POINT1 / RECT_FILL_POINT2 / RECT_FILL_COLOR register map from graphics_pkg.

Parameters:
- COORD_DATA_WIDTH, default vga_pkg::COORD_DATA_WIDTH: width of each x/y coordinate.
- COLOR_DATA_WIDTH, default vga_pkg::COLOR_DATA_WIDTH: width of the color field.
- MM_CSR_ADDR_WIDTH, default vga_pkg::MM_CSR_ADDR_WIDTH: CSR address width.

Ports:
- clk  in  1  Single system clock; all logic on the rising edge.
- reset_n  in  1  Asynchronous, active-low reset.
- csr_address  in  MM_CSR_ADDR_WIDTH  Register address.
- csr_write  in  1  Write strobe.
- csr_writedata  in  32  Write data.
- csr_read  in  1  Read strobe.
- csr_readdata  out  32  Status: bit0 = busy, other bits 0.
- csr_waitrequest  out  1  Stalls writes while busy.
- st_data  out  ST_DATA_WIDTH  pixel_t beat; padding bits are 0.
- st_valid  out  1  Beat valid.
- st_ready  in  1  Sink ready.
- st_startofpacket  out  1  First pixel of a rectangle.
- st_endofpacket  out  1  Last pixel of a rectangle.

Behaviour:
- Reset values (async assert, sync-safe release): all CSR registers 0, state IDLE, st_valid 0, sop/eop 0, st_data 0, csr_readdata 0, csr_waitrequest 0.
- Coordinate register layout: writedata[2*CW-1:CW] = x, writedata[CW-1:0] = y, with CW = COORD_DATA_WIDTH. Color layout: writedata[COLOR_DATA_WIDTH-1:0]. Upper bits are ignored.
- Reads: zero wait, zero latency. csr_readdata = {31'b0, busy} combinationally for any address. busy = (state != IDLE).
- Writes:
  - csr_waitrequest = csr_write && busy, so the write is held until IDLE.
  - An accepted write to POINT1 or POINT2 stores the value only.
  - An accepted write to COLOR stores the color and moves IDLE -> SETUP on the next edge.
  - Writes to unmapped addresses are accepted and ignored.
  - A write and a read in the same cycle is illegal master behaviour; the read result still reflects current busy.
- States:
  - IDLE: st_valid 0.
  - SETUP (1 cycle): xmin/xmax = min/max(P1.x, P2.x); ymin/ymax likewise. Load cur_x = xmin, cur_y = ymin. Go to EMIT.
  - EMIT:
    - st_valid = 1; st_data = {0, cur_x, cur_y, color}.
    - sop = (cur_x == xmin && cur_y == ymin); eop = (cur_x == xmax && cur_y == ymax).
    - On st_valid && st_ready:
      - if eop, go to IDLE (st_valid low the next cycle);
      - else if cur_x == xmax, set cur_x = xmin and cur_y + 1;
      - else cur_x + 1.
    - While st_ready is low, st_data, valid, sop and eop are held stable.
- Output is registered; first beat is valid 2 cycles after the accepted COLOR write edge.
- Throughput: 1 pixel/cycle while st_ready is high.
- Order: row-major, y outer, x inner, ascending.
- Pixel count = (xmax - xmin + 1) * (ymax - ymin + 1).
- Boundaries:
  - P1 == P2: exactly one beat with sop = eop = 1.
  - Single row or single column is legal.
  - Corners may be given in any order.
  - Counters compare for equality only and never wrap; xmax = all-ones is legal.
  - The corner/color snapshot is taken in SETUP; CSR writes cannot occur while busy.
- Back-to-back fills: a COLOR write accepted in the eop handshake cycle's successor starts the next fill; there is no minimum gap beyond IDLE.
- Reset mid-fill: the stream aborts immediately; st_valid drops asynchronously; no eop is emitted.

Test Plan:
- P1=(2,3), P2=(4,4), COLOR=0x5, st_ready=1 -> 6 beats in order (2,3) (3,3) (4,3) (2,4) (3,4) (4,4); sop on the first, eop on the last; consecutive cycles; first beat 2 cycles after the write.
- P1=(10,7), P2=(8,5) -> normalised to 8..10 x 5..7; 9 beats starting (8,5), ending (10,7) with eop.
- P1=P2=(0,0), COLOR=0x1 -> one beat, sop=eop=1; busy reads 0 the cycle after the handshake.
- 2x2 fill with st_ready toggling 1,0,0,1,... -> no duplicated or dropped pixel; data held stable during stalls.
- COLOR write issued while busy -> csr_waitrequest=1 until IDLE, then accepted; second rectangle follows the first's eop.
- reset_n low during the 3rd beat of a 3x3 fill -> st_valid=0 immediately; after release, busy=0 and registers read/fill from 0.
